// File: rtl/row_max_scheduler.sv
// Row maximum / argmax scheduler for one fp16 attention score row.
// Feeds one element per cycle through a single fp16 comparator against the
// running maximum, then holds {max, idx} on a valid/ready output.
// Optional build macro: ROWMAX_TIE_LAST_EN (ties report the last occurrence).

// fp16 comparator: total order over non-NaN values, +0 ranks above -0.
module comparator #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  agb,
  output logic                  aeb,
  output logic                  unordered
);
  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;

  logic                  nan_a;
  logic                  nan_b;
  logic [DATA_WIDTH-1:0] key_a;
  logic [DATA_WIDTH-1:0] key_b;

  // Map sign-magnitude to an unsigned key so plain magnitude compare orders it.
  always_comb begin
    nan_a     = (&a[MAN_W +: EXP_W]) && (|a[MAN_W-1:0]);
    nan_b     = (&b[MAN_W +: EXP_W]) && (|b[MAN_W-1:0]);
    key_a     = a[DATA_WIDTH-1] ? ~a : {1'b1, a[DATA_WIDTH-2:0]};
    key_b     = b[DATA_WIDTH-1] ? ~b : {1'b1, b[DATA_WIDTH-2:0]};
    unordered = nan_a || nan_b;
    agb       = !unordered && (key_a > key_b);
    aeb       = !unordered && (a == b);
  end
endmodule

module row_max_scheduler #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_LEN    = 32,
  parameter int unsigned IDX_W      = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [IDX_W:0]        len_cfg,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  busy
);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;

  logic                  cmp_agb;
  logic                  cmp_aeb;
  logic                  cmp_unord;
  logic                  unused_unord;
  logic                  take_c;
  logic [CNT_W-1:0]      eff_len_c;

  // Single comparator: incoming element against the running maximum.
  comparator #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .a         (in_data),
    .b         (max_q),
    .agb       (cmp_agb),
    .aeb       (cmp_aeb),
    .unordered (cmp_unord)
  );

  // NaN ordering is already folded into agb/aeb; the flag itself is not needed.
  assign unused_unord = cmp_unord;

  // Zero or oversize lengths run a full row.
  assign eff_len_c = ((len_cfg == '0) || (len_cfg > CNT_W'(ROW_LEN)))
                   ? CNT_W'(ROW_LEN) : len_cfg;

`ifdef ROWMAX_TIE_LAST_EN
  assign take_c = cmp_agb || cmp_aeb;
`else
  assign take_c = cmp_agb;
`endif

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    max_d   = max_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (!flush && start) begin
          len_d   = eff_len_c;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          count_d = '0;
          state_d = S_IDLE;
        end else if (in_valid && in_ready_q) begin
          if ((count_q == '0) || take_c) begin
            max_d = in_data;
            idx_d = IDX_W'(count_q);
          end
          count_d = count_q + CNT_W'(1);
          if (count_q == (len_q - CNT_W'(1))) begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (flush) begin
          count_d = '0;
          state_d = S_IDLE;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        count_d = '0;
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_RUN);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset clears the partial row immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      len_q       <= CNT_W'(ROW_LEN);
      max_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_max   = max_q;
  assign out_idx   = idx_q;
endmodule

// File: tb/tb_row_max_scheduler.sv
// Scoreboard bench for row_max_scheduler: driver pushes the reference result
// of each completed row, a negedge monitor pops it on the output handshake.
module tb_row_max_scheduler;
  localparam int ROW_LEN = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  len_cfg = '0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_max;
  logic [4:0]  out_idx;
  logic        busy;

  typedef struct {
    logic [15:0] mx;
    int          idx;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] row_data[64];
  int          checks = 0;
  int          errors = 0;

  row_max_scheduler dut (
    .clk(clk), .resetn(resetn), .start(start), .len_cfg(len_cfg), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---- reference model: fp16 values as real numbers ----
  function automatic bit is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1f) && (v[9:0] != 10'h0);
  endfunction

  function automatic real fp_val(input logic [15:0] v);
    int  e;
    int  m;
    real r;
    e = int'(v[14:10]);
    m = int'(v[9:0]);
    if (e == 31) r = 1.0e9;
    else if (e == 0) r = real'(m) / 16777216.0;
    else begin
      r = real'(1024 + m);
      for (int k = 0; k < e; k++) r = r * 2.0;
      r = r / 33554432.0;
    end
    return v[15] ? -r : r;
  endfunction

  function automatic bit fp_gt(input logic [15:0] a, input logic [15:0] b);
    if (is_nan(a) || is_nan(b)) return 1'b0;
    if (a[14:0] == 15'h0 && b[14:0] == 15'h0) return !a[15] && b[15];
    return fp_val(a) > fp_val(b);
  endfunction

  function automatic bit fp_eq(input logic [15:0] a, input logic [15:0] b);
    return !is_nan(a) && !is_nan(b) && (a == b);
  endfunction

  function automatic int eff_len(input int cfg);
    return (cfg == 0 || cfg > ROW_LEN) ? ROW_LEN : cfg;
  endfunction

  function automatic exp_t model(input int n);
    exp_t r;
    r.mx  = row_data[0];
    r.idx = 0;
    for (int i = 1; i < n; i++) begin
`ifdef ROWMAX_TIE_LAST_EN
      if (fp_gt(row_data[i], r.mx) || fp_eq(row_data[i], r.mx)) begin
`else
      if (fp_gt(row_data[i], r.mx)) begin
`endif
        r.mx  = row_data[i];
        r.idx = i;
      end
    end
    return r;
  endfunction

  // ---- monitor: pops on output handshake, flags unexpected results ----
  always @(negedge clk) begin
    exp_t e;
    if (resetn && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got out_valid=1 expected no pending result at %0t", $time);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        chk("mon_out_max", int'(out_max), int'(e.mx));
        chk("mon_out_idx", int'(out_idx), e.idx);
      end
    end
  end

  task automatic pulse_start(input int cfg);
    @(posedge clk); #1;
    start = 1'b1;
    len_cfg = 6'(cfg);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode: 0 = in_valid held, 1 = alternating bubbles, 2 = random bubbles
  task automatic run_row(input int cfg, input int mode, input int hold, input bit poke_start);
    int   n;
    int   got;
    int   cyc;
    bit   hs;
    exp_t e;
    n = eff_len(cfg);
    e = model(n);
    exp_q.push_back(e);
    pulse_start(cfg);
    chk("run_busy", int'(busy), 1);
    chk("run_in_ready", int'(in_ready), 1);
    got = 0;
    cyc = 0;
    while (got < n && cyc < 400) begin
      if (mode == 0) in_valid = 1'b1;
      else if (mode == 1) in_valid = (cyc % 2 == 0);
      else in_valid = 1'($urandom_range(0, 1));
      in_data = row_data[got];
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) got++;
      cyc++;
    end
    in_valid = 1'b0;
    if (got < n) chk("row_handshake_timeout", got, n);
    chk("latency_out_valid", int'(out_valid), 1);
    chk("out_in_ready_low", int'(in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      if (poke_start && h == 0) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_out_max", int'(out_max), int'(e.mx));
      chk("hold_out_idx", int'(out_idx), e.idx);
      chk("hold_busy", int'(busy), 1);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", int'(out_valid), 0);
    chk("post_busy", int'(busy), 0);
  endtask

  // Abort after nacc handshakes by flush or by asynchronous reset.
  task automatic abort_row(input int cfg, input int nacc, input bit use_reset);
    pulse_start(cfg);
    for (int i = 0; i < nacc; i++) begin
      in_valid = 1'b1;
      in_data = row_data[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (use_reset) begin
      #2 resetn = 1'b0;
      #1;
      chk("rst_out_max", int'(out_max), 0);
      chk("rst_out_idx", int'(out_idx), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      resetn = 1'b1;
    end else begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", int'(busy), 0);
      chk("flush_in_ready", int'(in_ready), 0);
      chk("flush_out_valid", int'(out_valid), 0);
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  function automatic logic [15:0] rand_elem();
    logic [15:0] pool[5];
    pool[0] = 16'h0000; pool[1] = 16'h8000; pool[2] = 16'h3C00;
    pool[3] = 16'hBC00; pool[4] = 16'h4200;
    if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 4)];
    return 16'($urandom());
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_out_max", int'(out_max), 0);
    chk("reset_out_idx", int'(out_idx), 0);
    resetn = 1'b1;

    // Basic row, with backpressure and a start poked during OUT.
    row_data[0] = 16'h3C00; row_data[1] = 16'h4000;
    row_data[2] = 16'h3E00; row_data[3] = 16'h3800;
    run_row(4, 0, 5, 1'b1);

    // Full length, all negative except the last element.
    for (int i = 0; i < 32; i++) row_data[i] = 16'hC000;
    row_data[31] = 16'h3555;
    run_row(0, 0, 1, 1'b0);

    // Ties.
    row_data[0] = 16'h4200; row_data[1] = 16'h4200; row_data[2] = 16'h3C00;
    run_row(3, 0, 2, 1'b0);

    // +0 versus -0 ordering.
    row_data[0] = 16'h8000; row_data[1] = 16'h0000; row_data[2] = 16'h8000;
    run_row(3, 0, 0, 1'b0);

    // Bubbles on the input, short row.
    row_data[0] = 16'h1234; row_data[1] = 16'h5678;
    run_row(2, 1, 5, 1'b0);

    // Flush mid-row, then a single-element row.
    for (int i = 0; i < 8; i++) row_data[i] = 16'h4400 + 16'(i);
    abort_row(8, 3, 1'b0);
    row_data[0] = 16'hBC00;
    run_row(1, 0, 1, 1'b0);

    // Asynchronous reset mid-row.
    for (int i = 0; i < 8; i++) row_data[i] = 16'h4800 + 16'(i);
    abort_row(8, 3, 1'b1);

    // Length clamp.
    for (int i = 0; i < 64; i++) row_data[i] = rand_elem();
    run_row(40, 0, 1, 1'b0);

    // Randomised rows.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 64; i++) row_data[i] = rand_elem();
      run_row(int'($urandom_range(0, 63)), 2, int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
